yarp_rf_wb_arbiter: RTL
=======================

// Module: yarp_rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port among NUM_REQ writeback requesters
//  (e.g. ALU, load unit, CSR unit) using round-robin arbitration over valid/ready.
//  Registers the winning write into a one-entry output stage that drives the regfile write port.
//  Flags read-after-write hazards while that write is still in flight.
//  Sits between the execute/memory writeback sources and yarp_regfile.
// PARAMETERS
//  NUM_REQ  3   number of writeback requesters (2..8)
//  XLEN     32  data width of a register
// PORTS
//  clk              in   1               clock
//  reset_n          in   1               reset, synchronous, active-low
//  hold_i           in   1               1 = grant nothing this cycle (halt/debug)
//  req_valid_i      in   NUM_REQ         per-requester write request valid
//  req_rd_addr_i    in   NUM_REQ x 5     per-requester destination register
//  req_data_i       in   NUM_REQ x XLEN  per-requester write data
//  req_ready_o      out  NUM_REQ         one-hot grant; transfer = valid & ready
//  rf_wr_en_o       out  1               to regfile wr_en_i (registered)
//  rf_rd_addr_o     out  5               to regfile rd_addr_i (registered)
//  rf_wr_data_o     out  XLEN            to regfile wr_data_i (registered)
//  rs1_addr_i       in   5               decode-stage rs1 being read
//  rs2_addr_i       in   5               decode-stage rs2 being read
//  rs1_hazard_o     out  1               rs1 matches the in-flight write
//  rs2_hazard_o     out  1               rs2 matches the in-flight write
//  stall_cnt_o      out  NUM_REQ x 16    per-requester stall counters (YARP_RF_WB_STATS_EN)
// BEHAVIOUR
//  - Reset: rf_wr_en_o=0, rf_rd_addr_o=0, rf_wr_data_o=0, rr_ptr=0, stall_cnt_o=0.
//  - Reset mid-operation discards any in-flight write; no regfile write occurs that cycle.
//  - Grant (combinational):
//      - If hold_i=1 or no valid request: req_ready_o=0.
//      - Otherwise grant the first valid requester scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
//      - req_ready_o is one-hot or zero. It never depends on its own requester's ready.
//  - Pointer: after a transfer by requester g, rr_ptr <= (g+1) mod NUM_REQ.
//      - rr_ptr is unchanged on idle or hold cycles.
//      - Fairness: a continuously valid requester is granted within NUM_REQ cycles of hold_i=0.
//  - Output stage: 1-cycle latency, one write per cycle. The regfile never back-pressures.
//      - Cycle N transfer (addr A, data D) -> cycle N+1: rf_wr_en_o=(A!=0), rf_rd_addr_o=A,
//        rf_wr_data_o=D.
//      - No transfer in cycle N -> rf_wr_en_o=0 in N+1; addr and data hold their previous values.
//  - x0 filter: a request with rd_addr=0 is still granted and accepted,
//    but produces rf_wr_en_o=0.
//  - Requester rules: once valid is high, addr and data stay stable until the transfer.
//      - Dropping valid before ready is allowed (request withdrawn, no side effects).
//  - Hazard (combinational):
//      - rsN_hazard_o = rf_wr_en_o & (rsN_addr_i == rf_rd_addr_o) & (rsN_addr_i != 0).
//      - Needed because regfile reads are registered: a read in the write cycle returns old data.
//  - Simultaneous valids in the same cycle: exactly one is granted; the others wait.
//  - hold_i asserted while the output stage is full: the pending write still completes
//    next cycle; only new grants are blocked.
// CONFIGURATION
//  - YARP_RF_WB_STATS_EN defined: stall_cnt_o[i] increments each cycle
//    req_valid_i[i] & ~req_ready_o[i].
//      - Counters saturate at 16'hFFFF.
//      - They clear only on reset.
//  - YARP_RF_WB_STATS_EN undefined: no counter flops; stall_cnt_o is tied to 0.
// STRUCTURE
//  - Package yarp_rf_pkg:
//      - XLEN=32, RF_ADDR_W=5.
//      - typedef rf_wr_req_t {logic [4:0] addr; logic [XLEN-1:0] data;}.
//  - Sub-module yarp_rr_arbiter #(NUM_REQ):
//      - Inputs: req vector, hold, transfer-accepted.
//      - Outputs: one-hot grant and grant index; it holds rr_ptr.
//  - Top level: data/addr mux by grant index, output register, hazard compare, stats counters.
// TESTING
//  - Single requester: req0 addr=5 data=0xDEADBEEF held 1 cycle
//      -> ready0=1 same cycle; next cycle wr_en=1, addr=5, data=0xDEADBEEF.
//  - All 3 requesters valid continuously from reset -> grants 0,1,2,0,1,2;
//    one rf write per cycle, in that order.
//  - req1 addr=0 data=0x1234 -> ready1=1; next cycle rf_wr_en_o=0; rr_ptr advances to 2.
//  - Write addr=7 in flight with rs1_addr_i=7, rs2_addr_i=0
//      -> rs1_hazard_o=1, rs2_hazard_o=0; both 0 on the following idle cycle.
//  - hold_i=1 for 4 cycles with req0 and req2 valid -> no ready, wr_en=0;
//    with STATS_EN, stall_cnt[0]=stall_cnt[2]=4.
//  - reset_n=0 the cycle after a transfer -> rf_wr_en_o=0 next cycle, rr_ptr=0,
//    and req0 is granted first once reset is released.

Source files
------------

// File: rtl/yarp_rf_wb_arbiter_pkg.sv
// Shared constants, the regfile write-request type and the round-robin wrap helper
// for the register-file writeback arbiter slice.
package yarp_rf_pkg;

  localparam int XLEN      = 32;
  localparam int RF_ADDR_W = 5;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [XLEN-1:0]      data;
  } rf_wr_req_t;

  // (base + inc) mod n, valid for base < n and inc < n.
  function automatic int rr_wrap_add(input int base, input int inc, input int n);
    int s;
    s = base + inc;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/yarp_rf_wb_arbiter_if.sv
// Writeback requester bundle: NUM_REQ parallel write requests toward the arbiter.
// Handshake: a transfer happens on a rising clk edge where req_valid_i[i] & req_ready_o[i];
// valid may drop before ready (withdrawal), addr/data stay stable while valid waits.
interface yarp_rf_wb_if #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = yarp_rf_pkg::XLEN
);
  logic [NUM_REQ-1:0]                              req_valid_i;
  logic [NUM_REQ-1:0][yarp_rf_pkg::RF_ADDR_W-1:0] req_rd_addr_i;
  logic [NUM_REQ-1:0][XLEN-1:0]                   req_data_i;
  logic [NUM_REQ-1:0]                              req_ready_o;

  modport master (
    output req_valid_i,
    output req_rd_addr_i,
    output req_data_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_rd_addr_i,
    input  req_data_i,
    output req_ready_o
  );
endinterface

// File: rtl/yarp_rf_wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant starting the scan at r_rr_ptr; the pointer moves
// past the winner only when the grant is actually taken.
module yarp_rr_arbiter
  import yarp_rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_hold,
  input  logic               i_xfer,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_gnt_idx
);

  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_idx     = '0;
    w_found   = 1'b0;
    if (!i_hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = PTR_W'(rr_wrap_add(int'(r_rr_ptr), k, NUM_REQ));
        if (!w_found && i_req[w_idx]) begin
          w_found      = 1'b1;
          o_gnt[w_idx] = 1'b1;
          o_gnt_idx    = w_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (i_xfer) begin
      r_rr_ptr <= PTR_W'(rr_wrap_add(int'(o_gnt_idx), 1, NUM_REQ));
    end
  end

endmodule

// File: rtl/yarp_rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin over NUM_REQ requesters, one registered
// write per cycle, RAW hazard flags. Optional stall counters under YARP_RF_WB_STATS_EN.
module yarp_rf_wb_arbiter
  import yarp_rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = yarp_rf_pkg::XLEN,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          hold_i,
  yarp_rf_wb_if.slave                   wb,
  output logic                          rf_wr_en_o,
  output logic [RF_ADDR_W-1:0]          rf_rd_addr_o,
  output logic [XLEN-1:0]               rf_wr_data_o,
  input  logic [RF_ADDR_W-1:0]          rs1_addr_i,
  input  logic [RF_ADDR_W-1:0]          rs2_addr_i,
  output logic                          rs1_hazard_o,
  output logic                          rs2_hazard_o,
  output logic [NUM_REQ-1:0][15:0]      stall_cnt_o
);

  logic [NUM_REQ-1:0]   w_gnt;
  logic [PTR_W-1:0]     w_gnt_idx;
  logic                 w_arb_hold;
  logic                 w_xfer;
  logic [RF_ADDR_W-1:0] w_sel_addr;
  logic [XLEN-1:0]      w_sel_data;

  logic                 r_wr_en;
  logic [RF_ADDR_W-1:0] r_wr_addr;
  logic [XLEN-1:0]      r_wr_data;

  // No grants while in reset, so a requester never sees a handshake that gets discarded.
  assign w_arb_hold = hold_i | ~reset_n;

  yarp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (wb.req_valid_i),
    .i_hold    (w_arb_hold),
    .i_xfer    (w_xfer),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  assign wb.req_ready_o = w_gnt;
  assign w_xfer         = |(wb.req_valid_i & w_gnt);
  assign w_sel_addr     = wb.req_rd_addr_i[w_gnt_idx];
  assign w_sel_data     = wb.req_data_i[w_gnt_idx];

  // Writes to x0 are accepted from the requester but never reach the regfile.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_xfer && (w_sel_addr != '0);
      if (w_xfer) begin
        r_wr_addr <= w_sel_addr;
        r_wr_data <= w_sel_data;
      end
    end
  end

  assign rf_wr_en_o   = r_wr_en;
  assign rf_rd_addr_o = r_wr_addr;
  assign rf_wr_data_o = r_wr_data;

  // Regfile reads are registered, so a read in the write cycle would return stale data.
  assign rs1_hazard_o = r_wr_en && (rs1_addr_i == r_wr_addr) && (rs1_addr_i != '0);
  assign rs2_hazard_o = r_wr_en && (rs2_addr_i == r_wr_addr) && (rs2_addr_i != '0);

`ifdef YARP_RF_WB_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (wb.req_valid_i[i] && !w_gnt[i] && (r_stall_cnt[i] != 16'hFFFF)) begin
          r_stall_cnt[i] <= r_stall_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
